scan_decoder: RTL and testbench

Parametrised, registered one-hot scan decoder: a prescaled index counter cycling through `OUT_WIDTH` positions, with each position decoded to a registered one-hot (or one-cold) select bus. It is the sequential successor of the combinational decoders. It drives digit/row selects for multiplexed seven-segment displays and LED matrices. The counter supports non-power-of-2 widths, synchronous index load, blanking, and a wrap pulse for the downstream data mux.

---
 rtl/scan_decoder_pkg.sv | 22 ++
 rtl/scan_decoder_if.sv | 28 ++
 rtl/scan_decoder_oprm.sv | 21 ++
 rtl/scan_decoder.sv | 124 ++++++++++++
 tb/tb_scan_decoder.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/scan_decoder_pkg.sv
// Shared types and helpers for the scan decoder family: select polarity,
// the per-edge action encoding, and the index-width rule.
package scan_pkg;

  localparam int SEL_ACTIVE_HIGH = 0;
  localparam int SEL_ACTIVE_LOW  = 1;

  typedef enum logic [1:0] {
    ACT_HOLD  = 2'd0,
    ACT_COUNT = 2'd1,
    ACT_STEP  = 2'd2,
    ACT_LOAD  = 2'd3
  } scan_act_e;

  // A one-position scan still needs a one-bit index port.
  function automatic int idx_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/scan_decoder_if.sv
// Control/status bundle of the scan decoder: scan controls in, index/select/wrap out.
interface scan_decoder_if
  import scan_pkg::*;
#(
  parameter int OUT_WIDTH = 4
) ();

  localparam int IDX_W = idx_width(OUT_WIDTH);

  logic                 en;
  logic                 load;
  logic [IDX_W-1:0]     load_idx;
  logic                 blank;
  logic [IDX_W-1:0]     idx;
  logic [OUT_WIDTH-1:0] out;
  logic                 wrap;

  modport master (
    output en, load, load_idx, blank,
    input  idx, out, wrap
  );

  modport slave (
    input  en, load, load_idx, blank,
    output idx, out, wrap
  );

endinterface

// File: rtl/scan_decoder_oprm.sv
// Combinational index-to-one-hot decoder; codes >= OUT_WIDTH decode to all-zero.
module decoder_oprm
  import scan_pkg::*;
#(
  parameter int OUT_WIDTH = 4
) (
  input  logic [idx_width(OUT_WIDTH)-1:0] sel,
  output logic [OUT_WIDTH-1:0]            dec
);

  localparam int IDX_W = idx_width(OUT_WIDTH);

  // one comparator per select line
  always_comb begin
    dec = {OUT_WIDTH{1'b0}};
    for (int i = 0; i < OUT_WIDTH; i++) begin
      dec[i] = (sel == IDX_W'(i));
    end
  end

endmodule

// File: rtl/scan_decoder.sv
// Prescaled scan counter with registered one-hot/one-cold select bus, blanking,
// synchronous index load and a wrap pulse for the downstream data mux.
module scan_decoder
  import scan_pkg::*;
#(
  parameter int OUT_WIDTH  = 4,
  parameter int DIV        = 4,
  parameter int ACTIVE_LOW = SEL_ACTIVE_HIGH
) (
  input  logic          clk,
  input  logic          rst,
  scan_decoder_if.slave bus
);

  localparam int IDX_W = idx_width(OUT_WIDTH);
  localparam int CNT_W = idx_width(DIV);

  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(OUT_WIDTH - 1);
  localparam logic [IDX_W:0]       OUT_W_L  = (IDX_W + 1)'(OUT_WIDTH);
  localparam logic [OUT_WIDTH-1:0] POL_MASK = (ACTIVE_LOW == SEL_ACTIVE_LOW) ?
                                              {OUT_WIDTH{1'b1}} : {OUT_WIDTH{1'b0}};
  localparam logic [OUT_WIDTH-1:0] RST_OUT  = OUT_WIDTH'(1) ^ POL_MASK;

  logic [CNT_W-1:0]     cnt_r;
  logic [IDX_W-1:0]     idx_r;
  logic                 wrap_r;
  logic [OUT_WIDTH-1:0] out_r;

  scan_act_e            act_s;
  logic                 load_ok_s;
  logic [CNT_W-1:0]     cnt_nxt_s;
  logic [IDX_W-1:0]     idx_nxt_s;
  logic                 wrap_nxt_s;
  logic [OUT_WIDTH-1:0] dec_s;
  logic [OUT_WIDTH-1:0] out_nxt_s;

  // out-of-range load codes only clear the prescaler
  assign load_ok_s = ({1'b0, bus.load_idx} < OUT_W_L);

  // per-edge action selection (load > step > count/hold) and counter next state
  always_comb begin
    act_s      = ACT_HOLD;
    cnt_nxt_s  = cnt_r;
    idx_nxt_s  = idx_r;
    wrap_nxt_s = 1'b0;

    if (bus.load) begin
      act_s = ACT_LOAD;
    end else if (bus.en) begin
      act_s = (cnt_r == CNT_LAST) ? ACT_STEP : ACT_COUNT;
    end else begin
      act_s = ACT_HOLD;
    end

    case (act_s)
      ACT_LOAD: begin
        cnt_nxt_s = {CNT_W{1'b0}};
        if (load_ok_s) begin
          idx_nxt_s = bus.load_idx;
        end else begin
          idx_nxt_s = idx_r;
        end
      end
      ACT_STEP: begin
        cnt_nxt_s = {CNT_W{1'b0}};
        if (idx_r == IDX_LAST) begin
          idx_nxt_s  = {IDX_W{1'b0}};
          wrap_nxt_s = 1'b1;
        end else begin
          idx_nxt_s  = idx_r + IDX_W'(1);
          wrap_nxt_s = 1'b0;
        end
      end
      ACT_COUNT: begin
        cnt_nxt_s = cnt_r + CNT_W'(1);
      end
      ACT_HOLD: begin
        cnt_nxt_s = cnt_r;
      end
      default: begin
        cnt_nxt_s = cnt_r;
      end
    endcase
  end

  // decode the next-state index so out and idx update on the same edge
  decoder_oprm #(
    .OUT_WIDTH (OUT_WIDTH)
  ) u_dec (
    .sel (idx_nxt_s),
    .dec (dec_s)
  );

  // blank masking then polarity
  always_comb begin
    out_nxt_s = {OUT_WIDTH{1'b0}};
    if (bus.blank) begin
      out_nxt_s = POL_MASK;
    end else begin
      out_nxt_s = dec_s ^ POL_MASK;
    end
  end

  // prescaler, index, wrap and select registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r  <= {CNT_W{1'b0}};
      idx_r  <= {IDX_W{1'b0}};
      wrap_r <= 1'b0;
      out_r  <= RST_OUT;
    end else begin
      cnt_r  <= cnt_nxt_s;
      idx_r  <= idx_nxt_s;
      wrap_r <= wrap_nxt_s;
      out_r  <= out_nxt_s;
    end
  end

  assign bus.idx  = idx_r;
  assign bus.out  = out_r;
  assign bus.wrap = wrap_r;

endmodule

// File: tb/tb_scan_decoder.sv
// Randomized bench: four scan_decoder configurations driven side by side and
// compared every cycle against a behavioural scan model.
module tb_scan_decoder;

  logic       clk;
  logic       rst;
  logic [3:0] en_v;
  logic       load_v;
  logic       blank_v;
  logic [1:0] li_v;

  int n_chk;
  int n_pass;

  // configurations: A(4,1,high) B(3,2,high) C(4,4,low) D(1,3,high)
  int pw  [4] = '{4, 3, 4, 1};
  int pd  [4] = '{1, 2, 4, 3};
  int pa  [4] = '{0, 0, 1, 0};
  int piw [4] = '{2, 2, 2, 1};

  int m_cnt  [4];
  int m_idx  [4];
  int m_wrap [4];
  int m_out  [4];

  scan_decoder_if #(.OUT_WIDTH(4)) ifa ();
  scan_decoder_if #(.OUT_WIDTH(3)) ifb ();
  scan_decoder_if #(.OUT_WIDTH(4)) ifc ();
  scan_decoder_if #(.OUT_WIDTH(1)) ifd ();

  assign ifa.en = en_v[0];  assign ifa.load = load_v;  assign ifa.blank = blank_v;  assign ifa.load_idx = li_v;
  assign ifb.en = en_v[1];  assign ifb.load = load_v;  assign ifb.blank = blank_v;  assign ifb.load_idx = li_v;
  assign ifc.en = en_v[2];  assign ifc.load = load_v;  assign ifc.blank = blank_v;  assign ifc.load_idx = li_v;
  assign ifd.en = en_v[3];  assign ifd.load = load_v;  assign ifd.blank = blank_v;  assign ifd.load_idx = li_v[0];

  scan_decoder #(.OUT_WIDTH(4), .DIV(1), .ACTIVE_LOW(0)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  scan_decoder #(.OUT_WIDTH(3), .DIV(2), .ACTIVE_LOW(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  scan_decoder #(.OUT_WIDTH(4), .DIV(4), .ACTIVE_LOW(1)) dut_c (.clk(clk), .rst(rst), .bus(ifc));
  scan_decoder #(.OUT_WIDTH(1), .DIV(3), .ACTIVE_LOW(0)) dut_d (.clk(clk), .rst(rst), .bus(ifd));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pol_mask(input int k);
    return (pa[k] != 0) ? ((1 << pw[k]) - 1) : 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_cnt[k]  = 0;
      m_idx[k]  = 0;
      m_wrap[k] = 0;
      m_out[k]  = 1 ^ pol_mask(k);
    end
  endtask

  // one clock edge of the scan as described behaviourally
  task automatic model_step();
    int lv;
    for (int k = 0; k < 4; k++) begin
      lv = int'(li_v) & ((1 << piw[k]) - 1);
      m_wrap[k] = 0;
      if (load_v) begin
        m_cnt[k] = 0;
        if (lv < pw[k]) m_idx[k] = lv;
      end else if (en_v[k]) begin
        if (m_cnt[k] == pd[k] - 1) begin
          m_cnt[k]  = 0;
          m_wrap[k] = (m_idx[k] == pw[k] - 1) ? 1 : 0;
          m_idx[k]  = (m_idx[k] + 1) % pw[k];
        end else begin
          m_cnt[k] = m_cnt[k] + 1;
        end
      end
      m_out[k] = (blank_v ? 0 : (1 << m_idx[k])) ^ pol_mask(k);
    end
  endtask

  task automatic check_inst(input string ph, input string nm, input int k,
                            input logic [31:0] idx, input logic [31:0] out,
                            input logic [31:0] wrap);
    check($sformatf("%s.%s.idx", ph, nm),  idx,  32'(m_idx[k]));
    check($sformatf("%s.%s.out", ph, nm),  out,  32'(m_out[k]));
    check($sformatf("%s.%s.wrap", ph, nm), wrap, 32'(m_wrap[k]));
  endtask

  task automatic check_all(input string ph);
    check_inst(ph, "A", 0, 32'(ifa.idx), 32'(ifa.out), 32'(ifa.wrap));
    check_inst(ph, "B", 1, 32'(ifb.idx), 32'(ifb.out), 32'(ifb.wrap));
    check_inst(ph, "C", 2, 32'(ifc.idx), 32'(ifc.out), 32'(ifc.wrap));
    check_inst(ph, "D", 3, 32'(ifd.idx), 32'(ifd.out), 32'(ifd.wrap));
  endtask

  task automatic tick(input string ph);
    @(posedge clk);
    model_step();
    #1;
    check_all(ph);
  endtask

  // asynchronous reset between edges, with blank held high to show it is ignored
  task automatic async_reset(input string ph);
    #2;
    rst     = 1'b1;
    blank_v = 1'b1;
    #1;
    model_reset();
    check_all({ph, ".now"});
    @(posedge clk);
    #1;
    check_all({ph, ".hold"});
    rst     = 1'b0;
    blank_v = 1'b0;
  endtask

  initial begin
    bit found;
    n_chk   = 0;
    n_pass  = 0;
    rst     = 1'b1;
    en_v    = 4'b0000;
    load_v  = 1'b0;
    blank_v = 1'b1;
    li_v    = 2'd0;
    model_reset();
    #1;
    check_all("por");
    @(posedge clk);
    #1;
    check_all("por_edge");
    rst     = 1'b0;
    blank_v = 1'b0;

    // free-running scan
    en_v = 4'b1111;
    for (int i = 0; i < 11; i++) tick("run");

    // load on A's step cycle at idx 3; out-of-range code 3 for B
    li_v   = 2'd2;
    load_v = 1'b1;
    tick("load2");
    li_v   = 2'd3;
    tick("load3");
    load_v = 1'b0;

    // gated enable pattern
    for (int i = 0; i < 6; i++) begin
      en_v = (i == 1 || i == 4) ? 4'b0000 : 4'b1111;
      tick("gate");
    end

    // blank for three cycles mid-scan
    en_v    = 4'b1111;
    blank_v = 1'b1;
    for (int i = 0; i < 3; i++) tick("blank");
    blank_v = 1'b0;
    for (int i = 0; i < 3; i++) tick("unblank");

    // reset mid-scan with C at idx 2, cnt 1
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (m_idx[2] == 2 && m_cnt[2] == 1) found = 1'b1;
      else tick("seek");
    end
    check("seek_c_idx2_cnt1", 32'(found), 32'd1);
    async_reset("arst");
    for (int i = 0; i < 6; i++) tick("post_rst");

    // randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < 4; k++) en_v[k] = ($urandom_range(0, 3) != 0);
      load_v = ($urandom_range(0, 15) == 0);
      li_v   = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) blank_v = ~blank_v;
      if (i % 150 == 149) async_reset("rnd_rst");
      else tick("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
